sevenseg_scan_capture: RTL
==========================

Name: sevenseg_scan_capture

Overview:
Sits at the receiving end of a multiplexed seven-segment display bus. Examples of such a bus are an FPGA-to-panel link or a loopback tap used in self-test. The block synchronises and debounces the shared segment lines and the digit-select lines, then maps each segment pattern back to a 4-bit BCD value and assembles a complete multi-digit frame. Pattern errors and select errors are flagged.

Parameters:
DIGITS, 4, number of multiplexed digits (1..8)
STABLE_CYCLES, 4, consecutive cycles a bus value must hold before capture (2..255)
SYNC_STAGES, 2, input synchroniser depth (0 = inputs already synchronous)

Ports:
clk  input  1  system clock, rising edge
reset_n  input  1  asynchronous active-low reset
seg  input  7  segment lines, active-high; bit6=a, bit5=b, ..., bit0=g
dig_sel  input  DIGITS  digit enables, active-high, expected one-hot or all-zero
err_clr  input  1  clears both sticky error flags
frame_bcd  output  4*DIGITS  captured frame; digit i occupies bits [4i+3:4i]
frame_blank  output  DIGITS  digit i was blank (seg=0) in the captured frame
frame_done  output  1  one-cycle pulse when frame_bcd/frame_blank update
frame_valid  output  1  at least one frame captured since reset
err_pattern  output  1  sticky: an undecodable segment pattern was captured
err_select  output  1  sticky: dig_sel was multi-hot at a capture point

Behaviour:
- Reset (asynchronous, reset_n=0): all outputs 0; synchroniser, stability counter, seen mask and working digit registers cleared.
- Synchroniser: seg and dig_sel each pass through SYNC_STAGES flops. Below, "cur" means the synchronised {seg,dig_sel}.
- Stability qualifier:
  - prev = cur delayed one cycle.
  - cnt <= (cur != prev) ? 0 : min(cnt+1, STABLE_CYCLES).
  - cap = (cur == prev) && (cnt == STABLE_CYCLES-1).
  - Capture therefore fires exactly once per held value, STABLE_CYCLES cycles after cur settles. It does not re-fire while the value is held.
- Decode table (seg -> BCD): 1111110->0, 0110000->1, 1101101->2, 1111001->3, 0110011->4, 1011011->5, 1011111->6, 1110000->7, 1111111->8, 1110011->9. 0000000 -> blank. Any other pattern -> invalid.
- On cap:
  - dig_sel all-zero: inter-digit blanking interval; no action.
  - dig_sel one-hot at index i:
    - Decimal pattern: work_bcd[i] <= value, work_blank[i] <= 0.
    - Blank pattern: work_bcd[i] <= 0, work_blank[i] <= 1.
    - Invalid pattern: work_bcd[i] <= 0xF, work_blank[i] <= 0, err_pattern <= 1.
    - In all three cases seen[i] <= 1.
  - dig_sel multi-hot: err_select <= 1; no digit or seen update.
- Frame completion:
  - When a capture sets the last missing bit of seen (seen | newbit == all-ones), the same edge does the following:
    - frame_bcd/frame_blank <= working registers, including the digit just captured.
    - frame_done <= 1 for one cycle; frame_valid <= 1.
    - seen <= 0.
  - Re-capturing a digit already in seen overwrites work_bcd[i] and does not advance the frame.
  - DIGITS=1: every capture completes a frame.
- Output latency: a change on seg/dig_sel reaches frame_bcd after SYNC_STAGES + STABLE_CYCLES + 1 clock edges, provided it completes the frame.
- err_clr: errors clear on the next edge. If err_clr and a new error event occur in the same cycle, the error wins (flag stays 1).
- Reset mid-frame discards partial work. The first frame after reset requires all DIGITS to be captured anew.
- All arithmetic is unsigned. cnt width is clog2(STABLE_CYCLES+1).

Decomposition:
- Package sevenseg_pkg:
  - typedef seg_t (logic[6:0]) and typedef bcd_t (logic[3:0]).
  - Constants SEG_0..SEG_9 and SEG_BLANK, using the encoding above and shared with the existing BCD-to-segment decoder.
  - BCD_INVALID = 4'hF.
- Sub-module sevenseg_pattern_decode: combinational seg_t -> {bcd_t, is_blank, is_invalid}.
- Synchroniser, qualifier and frame logic live in the top block.

Test Plan:
- Reset, then scan digits 0..3 with patterns for 1,2,3,4 (SEG held 8 cycles, 2-cycle all-zero gap between digits) -> one frame_done pulse; frame_bcd=16'h4321; frame_blank=0; frame_valid=1; no errors.
- Glitch: hold seg=SEG_5 on digit 0 for only 3 cycles, then SEG_7 for 8 cycles, then complete digits 1..3 -> frame_bcd[3:0]=7; 5 never appears.
- Blank plus invalid: digit 2 seg=0000000, digit 3 seg=1000001 -> frame_blank=4'b0100; frame_bcd[15:12]=F; err_pattern=1. Pulse err_clr -> err_pattern=0 next cycle; frame_bcd unchanged.
- Multi-hot: dig_sel=4'b0011 held 8 cycles -> err_select=1; seen unchanged, so no frame_done. err_clr asserted in the same cycle as a new multi-hot capture -> err_select stays 1.
- Repeat and reset: digits 0,1,1,2 then assert reset_n=0 for 1 cycle, then digits 3,0,1,2 -> no frame_done before reset; exactly one frame_done after digit 2 of the second pass; all outputs 0 during reset.
- Latency: single stable step with DIGITS=1, STABLE_CYCLES=4, SYNC_STAGES=2 -> frame_done asserts exactly 7 edges after the input change.

Source files
------------

// File: rtl/sevenseg_pkg.sv
// ============================================================================
// Module  : sevenseg_pkg
// Brief   : Shared seven-segment types and encodings (bit6=a ... bit0=g).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package sevenseg_pkg;

   typedef logic [6:0] seg_t;
   typedef logic [3:0] bcd_t;

   localparam seg_t SEG_0     = 7'b1111110;
   localparam seg_t SEG_1     = 7'b0110000;
   localparam seg_t SEG_2     = 7'b1101101;
   localparam seg_t SEG_3     = 7'b1111001;
   localparam seg_t SEG_4     = 7'b0110011;
   localparam seg_t SEG_5     = 7'b1011011;
   localparam seg_t SEG_6     = 7'b1011111;
   localparam seg_t SEG_7     = 7'b1110000;
   localparam seg_t SEG_8     = 7'b1111111;
   localparam seg_t SEG_9     = 7'b1110011;
   localparam seg_t SEG_BLANK = 7'b0000000;

   localparam bcd_t BCD_INVALID = 4'hF;

endpackage

`default_nettype wire

// File: rtl/sevenseg_pattern_decode.sv
// ============================================================================
// Module  : sevenseg_pattern_decode
// Brief   : Combinational segment pattern to BCD; flags blank and invalid.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module sevenseg_pattern_decode
   import sevenseg_pkg::*;
(
   input  seg_t i_seg,
   output bcd_t o_bcd,
   output logic o_is_blank,
   output logic o_is_invalid
);

   always_comb begin
      o_bcd        = BCD_INVALID;
      o_is_blank   = 1'b0;
      o_is_invalid = 1'b0;
      case (i_seg)
         SEG_0:     o_bcd = 4'd0;
         SEG_1:     o_bcd = 4'd1;
         SEG_2:     o_bcd = 4'd2;
         SEG_3:     o_bcd = 4'd3;
         SEG_4:     o_bcd = 4'd4;
         SEG_5:     o_bcd = 4'd5;
         SEG_6:     o_bcd = 4'd6;
         SEG_7:     o_bcd = 4'd7;
         SEG_8:     o_bcd = 4'd8;
         SEG_9:     o_bcd = 4'd9;
         SEG_BLANK: begin
            o_bcd      = 4'd0;
            o_is_blank = 1'b1;
         end
         default:   o_is_invalid = 1'b1;
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/sevenseg_scan_capture.sv
// ============================================================================
// Module  : sevenseg_scan_capture
// Brief   : Synchronise, debounce and decode a multiplexed 7-seg bus into frames.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module sevenseg_scan_capture
   import sevenseg_pkg::*;
#(
   parameter int DIGITS        = 4,
   parameter int STABLE_CYCLES = 4,
   parameter int SYNC_STAGES   = 2
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [6:0]            seg,
   input  logic [DIGITS-1:0]     dig_sel,
   input  logic                  err_clr,
   output logic [4*DIGITS-1:0]   frame_bcd,
   output logic [DIGITS-1:0]     frame_blank,
   output logic                  frame_done,
   output logic                  frame_valid,
   output logic                  err_pattern,
   output logic                  err_select
);

   localparam int                c_bus_w  = 7 + DIGITS;
   localparam int                c_cnt_w  = $clog2(STABLE_CYCLES + 1);
   localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(STABLE_CYCLES);
   localparam logic [c_cnt_w-1:0] c_cap_at  = c_cnt_w'(STABLE_CYCLES - 1);

   logic [c_bus_w-1:0]  w_raw;
   logic [c_bus_w-1:0]  w_cur;
   logic [c_bus_w-1:0]  r_prev;
   logic [c_cnt_w-1:0]  r_cnt;

   assign w_raw = {seg, dig_sel};

   generate
      if (SYNC_STAGES > 0) begin : g_sync
         logic [c_bus_w-1:0] r_sync [SYNC_STAGES];

         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
               for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
            end else begin
               r_sync[0] <= w_raw;
               for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
            end
         end

         assign w_cur = r_sync[SYNC_STAGES-1];
      end else begin : g_nosync
         assign w_cur = w_raw;
      end
   endgenerate

   // Counter saturates so a held value is captured exactly once.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_prev <= '0;
         r_cnt  <= '0;
      end else begin
         r_prev <= w_cur;
         if (w_cur != r_prev)
            r_cnt <= '0;
         else if (r_cnt != c_cnt_max)
            r_cnt <= r_cnt + c_cnt_w'(1);
      end
   end

   logic              w_cap;
   seg_t              w_seg;
   logic [DIGITS-1:0] w_sel;
   logic              w_sel_onehot;
   logic              w_sel_multi;

   assign w_cap        = (w_cur == r_prev) && (r_cnt == c_cap_at);
   assign w_seg        = w_cur[c_bus_w-1 -: 7];
   assign w_sel        = w_cur[DIGITS-1:0];
   assign w_sel_onehot = (w_sel != '0) && ((w_sel & (w_sel - DIGITS'(1))) == '0);
   assign w_sel_multi  = (w_sel != '0) && !w_sel_onehot;

   bcd_t w_dec_bcd;
   logic w_dec_blank;
   logic w_dec_invalid;

   sevenseg_pattern_decode u_decode (
      .i_seg        (w_seg),
      .o_bcd        (w_dec_bcd),
      .o_is_blank   (w_dec_blank),
      .o_is_invalid (w_dec_invalid)
   );

   logic [4*DIGITS-1:0] r_work_bcd;
   logic [DIGITS-1:0]   r_work_blank;
   logic [DIGITS-1:0]   r_seen;
   logic [4*DIGITS-1:0] w_work_bcd_nxt;
   logic [DIGITS-1:0]   w_work_blank_nxt;
   logic [DIGITS-1:0]   w_seen_nxt;
   logic                w_digit_cap;
   logic                w_frame_cmp;

   // Next working set includes the digit being captured so a completing
   // capture lands in the published frame on the same edge.
   always_comb begin
      w_work_bcd_nxt   = r_work_bcd;
      w_work_blank_nxt = r_work_blank;
      for (int i = 0; i < DIGITS; i++) begin
         if (w_sel[i]) begin
            w_work_bcd_nxt[4*i +: 4] = w_dec_bcd;
            w_work_blank_nxt[i]      = w_dec_blank;
         end
      end
   end

   assign w_seen_nxt  = r_seen | w_sel;
   assign w_digit_cap = w_cap && w_sel_onehot;
   assign w_frame_cmp = w_digit_cap && (&w_seen_nxt);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_work_bcd   <= '0;
         r_work_blank <= '0;
         r_seen       <= '0;
         frame_bcd    <= '0;
         frame_blank  <= '0;
         frame_done   <= 1'b0;
         frame_valid  <= 1'b0;
         err_pattern  <= 1'b0;
         err_select   <= 1'b0;
      end else begin
         frame_done <= w_frame_cmp;

         if (w_digit_cap) begin
            r_work_bcd   <= w_work_bcd_nxt;
            r_work_blank <= w_work_blank_nxt;
            r_seen       <= w_frame_cmp ? '0 : w_seen_nxt;
         end

         if (w_frame_cmp) begin
            frame_bcd   <= w_work_bcd_nxt;
            frame_blank <= w_work_blank_nxt;
            frame_valid <= 1'b1;
         end

         // A new error event takes priority over a simultaneous clear.
         if (w_digit_cap && w_dec_invalid)
            err_pattern <= 1'b1;
         else if (err_clr)
            err_pattern <= 1'b0;

         if (w_cap && w_sel_multi)
            err_select <= 1'b1;
         else if (err_clr)
            err_select <= 1'b0;
      end
   end

endmodule

`default_nettype wire
